vga_stream_check: RTL and testbench
===================================

# vga_stream_check

Passive receiver-side monitor for the `vga_if` pixel stream. It taps the output of any drawing stage, or the final stream before the DAC, and checks the stream against the SVGA timing contract. It reports sticky error flags, an error count and a frame count, and can capture the RGB value at one programmable pixel coordinate. It drives no `vga_if` signals; it is purely a sink for debug and self-check.

## Interface
- `H_TOTAL`, 1056: pixels per line, including blanking.
- `H_ACTIVE`, 800: visible pixels per line.
- `V_TOTAL`, 628: lines per frame.
- `V_ACTIVE`, 600: visible lines per frame.
- `HSYNC_W`, 128: required hsync pulse width, in pixels.
- `VSYNC_W`, 4: required vsync pulse width, in lines.
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `in` vga_if.in: monitored stream (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb).
- `clr` in 1: one-cycle pulse that clears `err_flags` and `err_cnt`.
- `pix_x` in 12: capture column; must be held stable for a whole frame.
- `pix_y` in 12: capture row; must be held stable for a whole frame.
- `locked` out 1: the checker is aligned to the frame.
- `frame_cnt` out 16: number of frames started while locked; wraps modulo 2^16.
- `err_flags` out 4: sticky error bits. [0] count sequence, [1] blank mismatch, [2] rgb in blanking, [3] sync width.
- `err_cnt` out 16: number of cycles with at least one error while locked; saturates at 0xFFFF.
- `pix_rgb` out 12: RGB value captured at (`pix_x`, `pix_y`).
- `pix_valid` out 1: one-cycle pulse when `pix_rgb` is updated.

## Operation
- **Stage A** registers every `in` field on each clock edge. **Stage B** holds the previous Stage A contents. All checks compare A against B and against the parameters. Check results are registered into the outputs.
- **State machine:**
  - States are SEEK and LOCKED.
  - SEEK → LOCKED when A has hcount==0 and vcount==0.
  - LOCKED → SEEK on any `err_flags[0]` event.
  - The reset state is SEEK.
  - `locked` is high only in LOCKED.
- **err[0], count sequence.** In LOCKED, the expected hcount is B.hcount+1, or 0 when B.hcount==H_TOTAL-1.
  - Expected vcount equals B.vcount when hcount does not wrap.
  - On an hcount wrap, expected vcount is B.vcount+1, or 0 when B.vcount==V_TOTAL-1.
  - Any mismatch sets the error.
- **err[1], blank mismatch.** Set when A.hblnk != (A.hcount >= H_ACTIVE), or when A.vblnk != (A.vcount >= V_ACTIVE).
- **err[2], rgb in blanking.** Set when (A.hblnk or A.vblnk) and A.rgb != 0.
- **err[3], sync width.**
  - A 12-bit hsync counter counts consecutive high cycles of A.hsync. On a falling edge of A.hsync, the error is set if the count != HSYNC_W.
  - A vsync line counter counts hcount wraps while A.vsync is high. On a falling edge of A.vsync, the error is set if the count != VSYNC_W.
  - A pulse that began before lock is ignored, so only pulses whose rising edge occurs in LOCKED are checked.
- **Error flags and counter.**
  - Errors are evaluated only in LOCKED. In SEEK nothing is flagged or counted.
  - `err_flags` is the OR of the new errors into the sticky value.
  - `err_cnt` increments by 1 per erroring cycle, regardless of how many bits are set.
  - `clr` clears both registers. When `clr` coincides with an error, the new error wins: flags = new bits and count = 1.
- **frame_cnt** increments once when LOCKED and A holds (0,0) after a B that was not (0,0). It does not increment on the SEEK → LOCKED transition itself.
- **Pixel capture.** When A.hcount==`pix_x` and A.vcount==`pix_y`, in either state, `pix_rgb` <= A.rgb and `pix_valid` pulses. Coordinates outside the active area still capture (the value is 0 on a legal stream).
- **Arithmetic.** All counters are unsigned. Comparisons use the full 12-bit widths.

## Timing
- **Latency.** A sample on `in` at edge k reaches Stage A at edge k. Its effect on `locked`, `err_*`, `frame_cnt` and `pix_*` is visible after edge k+1, which is 2 edges after it is presented.
- **Reset.** `locked` = 0, `frame_cnt` = 0, `err_flags` = 0, `err_cnt` = 0, `pix_rgb` = 0, `pix_valid` = 0. Stage A/B, the sync counters and the FSM are zeroed (FSM = SEEK).
- **Reset mid-frame.** The checker restarts in SEEK. The first legal (0,0) after reset locks it, and no error is raised for the partial frame.
- **Lock loss.** The cycle that raises err[0] also moves the FSM to SEEK. That cycle is counted; later cycles are not counted until relock.
- **pix_valid** is high for exactly one cycle per frame on a legal stream.

## Test plan
- **Clean stream.** Drive 3 legal frames starting at (0,0). Required: `locked`=1 two cycles after the first (0,0); `frame_cnt`=2 after the third frame start; `err_flags`=0; `err_cnt`=0.
- **Sequence fault.** In frame 2, hcount jumps from 100 to 102. Required: `err_flags`=4'b0001, `err_cnt`=1, `locked`=0; relock at the next (0,0); `frame_cnt` does not increment for the lost frame.
- **Blanking faults.** rgb=12'hFFF at (900,10) for one cycle, then hblnk=0 at (850,11). Required: `err_flags`=4'b0110, `err_cnt`=2.
- **Sync width faults.** An hsync pulse of 127 cycles gives `err_flags[3]`=1 and `err_cnt`=1 at its falling edge. A vsync pulse of 5 lines gives `err_flags[3]`=1 and `err_cnt`=2 at its falling edge.
- **Pixel capture.** Stream from a rectangle-drawing stage with pix=(10,20) and the rectangle covering (10,20). Required: `pix_rgb` = the rectangle colour, with one `pix_valid` pulse per frame.
- **Clear and reset.** Assert `clr` in the same cycle as an rgb-in-blank error. Required: `err_flags`=4'b0100, `err_cnt`=1. Then assert `rst` mid-frame. Required: all outputs read 0, with no errors raised before the next (0,0).

Source files
------------

// File: rtl/vga_stream_check_if.sv
// Pixel stream bundle shared by the timing generator, the drawing stages and
// the stream checker. Carries the 12-bit counters, syncs, blanks and RGB.
// Modports: in (sink side, all inputs), out (source side, all outputs).
interface vga_if;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_stream_check.sv
// Purpose : passive SVGA stream monitor; locks to the frame, checks counter
//           sequence, blanking, rgb-in-blank and sync widths, counts frames
//           and errors, and captures the rgb at one programmable coordinate.
// Latency : a sample on `in` is registered at edge k, results are visible
//           after edge k+1.
// Backpressure: none; the block is a pure sink and drives nothing upstream.
// Ports   : clk, rst (sync, active high), in (vga_if sink), clr (pulse that
//           clears err_flags/err_cnt), pix_x/pix_y (capture coordinate),
//           locked, frame_cnt, err_flags, err_cnt, pix_rgb, pix_valid.
module vga_stream_check #(
    parameter int H_TOTAL  = 1056,
    parameter int H_ACTIVE = 800,
    parameter int V_TOTAL  = 628,
    parameter int V_ACTIVE = 600,
    parameter int HSYNC_W  = 128,
    parameter int VSYNC_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    input  logic        clr,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    output logic        locked,
    output logic [15:0] frame_cnt,
    output logic [3:0]  err_flags,
    output logic [15:0] err_cnt,
    output logic [11:0] pix_rgb,
    output logic        pix_valid
);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
    localparam logic [11:0] HSYNC_12 = 12'(HSYNC_W);
    localparam logic [11:0] VSYNC_12 = 12'(VSYNC_W);

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } smp_t;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state, next_state;

    // Stage A: current sample. a_vld is low until the first sample after
    // reset has been taken, so the zeroed register never looks like (0,0).
    smp_t        a;
    logic        a_vld;

    // Stage B: only the fields the checks compare against are kept.
    logic [11:0] b_hcount;
    logic [11:0] b_vcount;
    logic        b_hsync;
    logic        b_vsync;

    // Sync pulse measurement; *_arm marks a pulse whose rising edge was seen
    // while locked, so pulses already running at lock time are not judged.
    logic [11:0] hs_cnt;
    logic [11:0] vs_cnt;
    logic        hs_arm;
    logic        vs_arm;

    logic        is_locked;
    logic        h_wrap;
    logic        line_wrap;
    logic [11:0] exp_h;
    logic [11:0] exp_v;
    logic        seq_err;
    logic        blank_err;
    logic        rgb_err;
    logic        hs_rise;
    logic        hs_fall;
    logic        vs_rise;
    logic        vs_fall;
    logic        hs_err;
    logic        vs_err;
    logic [3:0]  new_err;
    logic        any_err;
    logic        a_origin;
    logic        b_origin;

    assign is_locked = (state == LOCKED);
    assign locked    = is_locked;

    // ---------------------------------------------------------------
    // Stage A / Stage B registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            a_vld    <= 1'b0;
            b_hcount <= '0;
            b_vcount <= '0;
            b_hsync  <= 1'b0;
            b_vsync  <= 1'b0;
        end else begin
            a.hcount <= in.hcount;
            a.vcount <= in.vcount;
            a.hsync  <= in.hsync;
            a.vsync  <= in.vsync;
            a.hblnk  <= in.hblnk;
            a.vblnk  <= in.vblnk;
            a.rgb    <= in.rgb;
            a_vld    <= 1'b1;
            b_hcount <= a.hcount;
            b_vcount <= a.vcount;
            b_hsync  <= a.hsync;
            b_vsync  <= a.vsync;
        end
    end

    // ---------------------------------------------------------------
    // Checks: A against B and against the timing parameters
    // ---------------------------------------------------------------
    always_comb begin
        h_wrap    = (b_hcount == H_LAST);
        exp_h     = h_wrap ? 12'd0 : b_hcount + 12'd1;
        exp_v     = b_vcount;
        if (h_wrap) begin
            exp_v = (b_vcount == V_LAST) ? 12'd0 : b_vcount + 12'd1;
        end
        line_wrap = h_wrap && (a.hcount == 12'd0);

        seq_err   = (a.hcount != exp_h) || (a.vcount != exp_v);
        blank_err = (a.hblnk != (a.hcount >= H_ACT12)) ||
                    (a.vblnk != (a.vcount >= V_ACT12));
        rgb_err   = (a.hblnk || a.vblnk) && (a.rgb != 12'd0);

        hs_rise   =  a.hsync && !b_hsync;
        hs_fall   = !a.hsync &&  b_hsync;
        vs_rise   =  a.vsync && !b_vsync;
        vs_fall   = !a.vsync &&  b_vsync;
        hs_err    = hs_fall && hs_arm && (hs_cnt != HSYNC_12);
        vs_err    = vs_fall && vs_arm && (vs_cnt != VSYNC_12);

        new_err   = 4'd0;
        if (is_locked) begin
            new_err = {hs_err || vs_err, rgb_err, blank_err, seq_err};
        end
        any_err   = |new_err;

        a_origin  = (a.hcount == 12'd0) && (a.vcount == 12'd0);
        b_origin  = (b_hcount == 12'd0) && (b_vcount == 12'd0);
    end

    // ---------------------------------------------------------------
    // Lock state machine
    // ---------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            SEEK: begin
                if (a_vld && a_origin) begin
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (seq_err) begin
                    next_state = SEEK;
                end
            end
            default: next_state = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------
    // Sync width measurement
    // hs_cnt: consecutive high samples of A.hsync, restarted at 1 on a rise.
    // vs_cnt: line starts seen while A.vsync is high; a pulse that rises
    //         on a line start counts that line too.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_cnt <= '0;
            vs_cnt <= '0;
            hs_arm <= 1'b0;
            vs_arm <= 1'b0;
        end else begin
            if (hs_rise) begin
                hs_cnt <= 12'd1;
            end else if (a.hsync && (hs_cnt != 12'hFFF)) begin
                hs_cnt <= hs_cnt + 12'd1;
            end

            if (vs_rise) begin
                vs_cnt <= line_wrap ? 12'd1 : 12'd0;
            end else if (a.vsync && line_wrap && (vs_cnt != 12'hFFF)) begin
                vs_cnt <= vs_cnt + 12'd1;
            end

            if (hs_rise) begin
                hs_arm <= is_locked;
            end else if (hs_fall || !is_locked) begin
                hs_arm <= 1'b0;
            end

            if (vs_rise) begin
                vs_arm <= is_locked;
            end else if (vs_fall || !is_locked) begin
                vs_arm <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Error flags / counters, frame counter, pixel capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags <= '0;
            err_cnt   <= '0;
            frame_cnt <= '0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
        end else begin
            // A clear in the same cycle as a new error keeps only the new one.
            if (clr) begin
                err_flags <= new_err;
                err_cnt   <= any_err ? 16'd1 : 16'd0;
            end else begin
                err_flags <= err_flags | new_err;
                if (any_err && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end

            // Only a transition into (0,0) counts, so the lock cycle itself
            // (state still SEEK) never bumps the count.
            if (is_locked && a_origin && !b_origin) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            pix_valid <= 1'b0;
            if (a_vld && (a.hcount == pix_x) && (a.vcount == pix_y)) begin
                pix_rgb   <= a.rgb;
                pix_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_check.sv
// Directed bench for vga_stream_check on a scaled-down raster (20x10 total,
// 12x6 active, hsync 14..17, vsync lines 7..8) so whole frames stay short.
// Ports: drives clk, rst, clr, pix_x/pix_y and the vga_if stream; reads all
// checker outputs and compares them to hand-computed values.
module tb_vga_stream_check;

    localparam int HT  = 20;
    localparam int HA  = 12;
    localparam int VT  = 10;
    localparam int VA  = 6;
    localparam int HSW = 4;
    localparam int VSW = 2;
    localparam int HS0 = 14;
    localparam int VS0 = 7;

    localparam int K_LEGAL = 0;
    localparam int K_RGB   = 1;  // rgb forced to FFF
    localparam int K_HB0   = 2;  // hblnk forced low
    localparam int K_HSLO  = 3;  // hsync forced low
    localparam int K_VSHI  = 4;  // vsync forced high
    localparam int K_SKIP  = 5;  // one hcount value skipped

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [3:0]  err_flags;
    logic [15:0] err_cnt;
    logic [11:0] pix_rgb;
    logic        pix_valid;

    vga_if vif ();

    vga_stream_check #(
        .H_TOTAL (HT),
        .H_ACTIVE(HA),
        .V_TOTAL (VT),
        .V_ACTIVE(VA),
        .HSYNC_W (HSW),
        .VSYNC_W (VSW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (vif.in),
        .clr      (clr),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .locked   (locked),
        .frame_cnt(frame_cnt),
        .err_flags(err_flags),
        .err_cnt  (err_cnt),
        .pix_rgb  (pix_rgb),
        .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int pv_cnt = 0;
    int h      = 0;
    int v      = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
    endtask

    // Drive one pixel of the raster (optionally corrupted), clock it in,
    // then sample outputs 1 time unit after the edge.
    task automatic step(input int kind);
        if (kind == K_SKIP) adv();
        vif.hcount = 12'(h);
        vif.vcount = 12'(v);
        vif.hsync  = (h >= HS0) && (h < HS0 + HSW) && (kind != K_HSLO);
        vif.vsync  = ((v >= VS0) && (v < VS0 + VSW)) || (kind == K_VSHI);
        vif.hblnk  = (h >= HA) && (kind != K_HB0);
        vif.vblnk  = (v >= VA);
        if (h >= HA || v >= VA)
            vif.rgb = 12'h000;
        else if (h >= 2 && h <= 5 && v >= 1 && v <= 3)
            vif.rgb = 12'hA5C;   // rectangle
        else
            vif.rgb = 12'h123;   // background
        if (kind == K_RGB) vif.rgb = 12'hFFF;
        @(posedge clk);
        #1;
        if (pix_valid) pv_cnt++;
        adv();
    endtask

    task automatic run(input int n);
        repeat (n) step(K_LEGAL);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        pix_x = 12'd3;
        pix_y = 12'd2;
        vif.hcount = '0; vif.vcount = '0; vif.hsync = 1'b0; vif.vsync = 1'b0;
        vif.hblnk = 1'b0; vif.vblnk = 1'b0; vif.rgb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_frame",  frame_cnt, 16'd0);
        chk("rst_flags",  16'(err_flags), 16'd0);
        chk("rst_cnt",    err_cnt, 16'd0);
        chk("rst_pixrgb", 16'(pix_rgb), 16'd0);
        chk("rst_pixvld", 16'(pix_valid), 16'd0);

        // Clean stream: lock two edges after the first (0,0).
        rst = 1'b0;
        h = 0; v = 0;
        step(K_LEGAL);
        chk("lock_early", 16'(locked), 16'd0);
        step(K_LEGAL);
        chk("lock", 16'(locked), 16'd1);
        run(400);                           // through (1,0) of the third frame
        chk("clean_frame",  frame_cnt, 16'd2);
        chk("clean_flags",  16'(err_flags), 16'd0);
        chk("clean_cnt",    err_cnt, 16'd0);
        chk("clean_locked", 16'(locked), 16'd1);
        chk("pix_pulses",   16'(pv_cnt), 16'd2);
        chk("pix_rgb",      16'(pix_rgb), 16'hA5C);

        // Sequence fault: hcount 5 -> 7 on line 1.
        run(24);
        step(K_SKIP);
        step(K_LEGAL);
        chk("seq_flags",  16'(err_flags), 16'h1);
        chk("seq_cnt",    err_cnt, 16'd1);
        chk("seq_locked", 16'(locked), 16'd0);
        run(171);                           // up to (19,9) while unlocked
        chk("seek_nocount", err_cnt, 16'd1);
        chk("seek_locked",  16'(locked), 16'd0);
        step(K_LEGAL);                      // (0,0)
        step(K_LEGAL);
        chk("relock",       16'(locked), 16'd1);
        chk("relock_frame", frame_cnt, 16'd2);

        // Plain clear.
        clr = 1'b1;
        step(K_LEGAL);
        clr = 1'b0;
        chk("clr_flags", 16'(err_flags), 16'd0);
        chk("clr_cnt",   err_cnt, 16'd0);

        // Blanking faults: rgb FFF at (15,1), hblnk low at (13,2).
        run(32);
        step(K_RGB);
        step(K_LEGAL);
        chk("rgbblk_flags", 16'(err_flags), 16'h4);
        chk("rgbblk_cnt",   err_cnt, 16'd1);
        run(16);
        step(K_HB0);
        step(K_LEGAL);
        chk("blank_flags", 16'(err_flags), 16'h6);
        chk("blank_cnt",   err_cnt, 16'd2);
        clr = 1'b1;
        step(K_LEGAL);
        clr = 1'b0;
        chk("clr2_flags", 16'(err_flags), 16'd0);

        // Hsync 3 wide on line 3 (falls at 17 instead of 18).
        run(21);
        step(K_HSLO);
        step(K_LEGAL);
        chk("hs_flags", 16'(err_flags), 16'h8);
        chk("hs_cnt",   err_cnt, 16'd1);

        // Vsync 3 lines (7..9), falls at the next (0,0).
        run(101);
        repeat (HT) step(K_VSHI);
        step(K_LEGAL);
        chk("vs_prefall_cnt", err_cnt, 16'd1);
        step(K_LEGAL);
        chk("vs_flags",  16'(err_flags), 16'h8);
        chk("vs_cnt",    err_cnt, 16'd2);
        chk("vs_frame",  frame_cnt, 16'd3);
        chk("vs_locked", 16'(locked), 16'd1);

        // Clear coinciding with an rgb-in-blank error at (13,0).
        run(11);
        step(K_RGB);
        clr = 1'b1;
        step(K_LEGAL);
        clr = 1'b0;
        chk("clrerr_flags", 16'(err_flags), 16'h4);
        chk("clrerr_cnt",   err_cnt, 16'd1);

        // Reset mid-frame (line 3).
        run(50);
        rst = 1'b1;
        step(K_LEGAL);
        step(K_LEGAL);
        chk("mrst_locked", 16'(locked), 16'd0);
        chk("mrst_frame",  frame_cnt, 16'd0);
        chk("mrst_flags",  16'(err_flags), 16'd0);
        chk("mrst_cnt",    err_cnt, 16'd0);
        chk("mrst_pixrgb", 16'(pix_rgb), 16'd0);
        chk("mrst_pixvld", 16'(pix_valid), 16'd0);
        rst = 1'b0;
        pv_cnt = 0;
        run(133);                           // (7,3) .. (19,9), partial frame
        chk("partial_flags",  16'(err_flags), 16'd0);
        chk("partial_cnt",    err_cnt, 16'd0);
        chk("partial_locked", 16'(locked), 16'd0);
        chk("partial_pix",    16'(pv_cnt), 16'd0);
        step(K_LEGAL);                      // (0,0)
        step(K_LEGAL);
        chk("post_lock",  16'(locked), 16'd1);
        chk("post_frame", frame_cnt, 16'd0);
        chk("post_flags", 16'(err_flags), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
